aes_result_buffer: RTL and testbench



---
 rtl/DesignPkg.sv | 10 +
 rtl/result_fifo_ram.sv | 27 ++
 rtl/aes_result_buffer.sv | 105 ++++++++++
 tb/tb_aes_result_buffer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/DesignPkg.sv
// Shared design package: ciphertext type plus result-buffer sizing defaults.
package DesignPkg;

    typedef logic [127:0] text_t;

    localparam int AES_RESULT_DEPTH = 4;

    typedef logic [$clog2(AES_RESULT_DEPTH):0] result_cnt_t;

endpackage

// File: rtl/result_fifo_ram.sv
// DEPTH x 128 register array with one synchronous write port and one
// asynchronous (fall-through) read port.
module result_fifo_ram
    import DesignPkg::*;
#(
    parameter int DEPTH = AES_RESULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  text_t                    wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output text_t                    rd_data
);

    text_t mem [DEPTH];

    // Contents are never cleared; only occupancy tracking resets.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/aes_result_buffer.sv
// Result FIFO on the AES core output: captures final_text on each rising edge of
// finished_encrypt and streams it out over valid/ready. Optional AES_RESULT_CNT_EN
// adds a 32-bit count of accepted results.
module aes_result_buffer
    import DesignPkg::*;
#(
    parameter int DEPTH = AES_RESULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   finished_encrypt,
    input  text_t                  final_text,
    output logic                   buffer_space,
    output logic                   out_valid,
    output text_t                  out_text,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
`ifdef AES_RESULT_CNT_EN
    ,
    output logic [31:0]            result_total
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Stream handshake: a transfer happens on a clock edge where out_valid and
    // out_ready are both high; out_text is stable while out_valid is high and
    // out_ready is low.

    logic          fin_q;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          capture;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;
    logic [CW-1:0] count_next;

    assign capture   = finished_encrypt & ~fin_q;
    assign full      = (count == DEPTH_C);
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    // A full buffer still accepts a result when the head leaves in the same cycle.
    assign push      = capture & (~full | pop);
    assign drop      = capture & full & ~pop;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fin_q        <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            buffer_space <= 1'b1;
            overflow     <= 1'b0;
        end else begin
            fin_q        <= finished_encrypt;
            count        <= count_next;
            buffer_space <= (count_next < DEPTH_C);
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef AES_RESULT_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            result_total <= '0;
        end else if (push) begin
            result_total <= result_total + 32'd1;
        end
    end
`endif

    result_fifo_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push & ~reset),
        .wr_addr (wr_ptr),
        .wr_data (final_text),
        .rd_addr (rd_ptr),
        .rd_data (out_text)
    );

endmodule

// File: tb/tb_aes_result_buffer.sv
// Self-checking bench for aes_result_buffer (DEPTH = 4) with a queue scoreboard.
module tb_aes_result_buffer;
  import DesignPkg::*;

  localparam int DEPTH = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset;
  logic                   finished_encrypt;
  text_t                  final_text;
  logic                   buffer_space;
  logic                   out_valid;
  text_t                  out_text;
  logic                   out_ready;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
`ifdef AES_RESULT_CNT_EN
  logic [31:0]            result_total;
`endif

  aes_result_buffer #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .finished_encrypt (finished_encrypt),
    .final_text       (final_text),
    .buffer_space     (buffer_space),
    .out_valid        (out_valid),
    .out_text         (out_text),
    .out_ready        (out_ready),
    .count            (count),
    .overflow         (overflow)
`ifdef AES_RESULT_CNT_EN
    ,
    .result_total     (result_total)
`endif
  );

  // scoreboard and reference state
  logic [127:0] exp_q[$];
  logic         fin_m;
  logic         ovf_m;
  int unsigned  total_m;
  int           n_checks;
  int           n_pass;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_outputs();
    check("count", 128'(count), 128'(exp_q.size()));
    check("out_valid", 128'(out_valid), 128'(exp_q.size() != 0));
    check("buffer_space", 128'(buffer_space), 128'(exp_q.size() < DEPTH));
    check("overflow", 128'(overflow), 128'(ovf_m));
`ifdef AES_RESULT_CNT_EN
    check("result_total", 128'(result_total), 128'(total_m));
`endif
    if (exp_q.size() != 0) check("head_text", out_text, exp_q[0]);
  endtask

  // one clock with the current inputs; model advances alongside the DUT
  task automatic step();
    bit cap;
    bit pop;
    cap = finished_encrypt && !fin_m;
    pop = (exp_q.size() != 0) && out_ready;
    if (pop) begin
      check("pop_text", out_text, exp_q[0]);
      void'(exp_q.pop_front());
    end
    if (cap) begin
      if (exp_q.size() < DEPTH || pop) begin
        exp_q.push_back(final_text);
        total_m++;
      end else begin
        ovf_m = 1'b1;
      end
    end
    fin_m = finished_encrypt;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset(input logic keep_fe);
    reset = 1'b1;
    out_ready = 1'b0;
    finished_encrypt = keep_fe;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    fin_m = 1'b0;
    ovf_m = 1'b0;
    total_m = 0;
    check_outputs();
  endtask

  task automatic send(input logic [127:0] t, input int hold);
    final_text = t;
    finished_encrypt = 1'b1;
    for (int i = 0; i < hold; i++) step();
    finished_encrypt = 1'b0;
    step();
  endtask

  function automatic logic [127:0] rand_text();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic drain();
    int guard;
    guard = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && guard < 50) begin
      step();
      guard++;
    end
    out_ready = 1'b0;
    check("drain_done", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    total_m = 0;
    fin_m = 1'b0;
    ovf_m = 1'b0;
    final_text = '0;
    finished_encrypt = 1'b0;
    out_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // reset then idle
    do_reset(1'b0);
    repeat (3) step();

    // single result, level held 5 cycles
    send(128'h3925841d02dc09fbdc118597196a0b32, 5);
    check("single_count", 128'(count), 128'(1));
    check("single_text", out_text, 128'h3925841d02dc09fbdc118597196a0b32);
    step();
    drain();

    // fill, then overflow with a 5th result
    for (int i = 0; i < DEPTH; i++) send(rand_text(), 1);
    check("full_space", 128'(buffer_space), 128'(0));
    send(rand_text(), 2);
    check("ovf_set", 128'(overflow), 128'(1));
    check("ovf_count", 128'(count), 128'(DEPTH));
    drain();

    // push+pop at full, wrapping pointers through 10 results
    do_reset(1'b0);
    for (int i = 0; i < DEPTH; i++) send(rand_text(), 1);
    for (int i = 0; i < 10; i++) begin
      final_text = rand_text();
      finished_encrypt = 1'b1;
      out_ready = 1'b1;
      step();
      check("pp_count", 128'(count), 128'(DEPTH));
      finished_encrypt = 1'b0;
      out_ready = 1'b0;
      step();
    end
    check("pp_no_ovf", 128'(overflow), 128'(0));
    drain();

    // reset mid-operation with count 3 and overflow set; level high across reset
    for (int i = 0; i < DEPTH + 1; i++) send(rand_text(), 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("pre_rst_count", 128'(count), 128'(3));
    check("pre_rst_ovf", 128'(overflow), 128'(1));
    final_text = rand_text();
    do_reset(1'b1);
    step();
    finished_encrypt = 1'b0;
    step();
    check("post_rst_count", 128'(count), 128'(1));
    drain();

    // 6 accepted and 1 discarded result
    do_reset(1'b0);
    for (int i = 0; i < DEPTH; i++) send(rand_text(), 1);
    send(rand_text(), 1);
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    send(rand_text(), 1);
    send(rand_text(), 1);
`ifdef AES_RESULT_CNT_EN
    check("total_six", 128'(result_total), 128'(6));
`endif
    drain();

    // random traffic
    do_reset(1'b0);
    for (int i = 0; i < 200; i++) begin
      finished_encrypt = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      final_text = rand_text();
      step();
    end
    finished_encrypt = 1'b0;
    step();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
